// File: rtl/lfsr8_sequence_checker.sv
// lfsr8_sequence_checker
//   Receive-side checker for the 8-bit LFSR pattern driven by the LED blinker.
//   Seeds on any nonzero valid sample, locks after LOCK_COUNT consecutive
//   correct predictions, then flywheels its own prediction and flags every
//   sample that disagrees. Drops lock after UNLOCK_COUNT consecutive misses.
//
// Ports
//   aclk        in   clock, rising edge
//   areset      in   synchronous active-high reset
//   din[7:0]    in   sampled bus value
//   din_valid   in   din carries a new sample this cycle
//   clr_counts  in   clear error_count (wins over a same-cycle increment)
//   locked      out  checker is locked to the sequence
//   error_pulse out  one cycle per mispredicted sample while locked
//   wrap_pulse  out  one cycle per correctly predicted 0xFF while locked
//   error_count out  saturating mismatch count (survives unlock/relock)
//
// All outputs are registered: a sample captured on an edge shows its effect
// on the outputs right after that same edge.

module lfsr8_sequence_checker #(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3,
  parameter int ERR_W        = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [7:0]       din,
  input  logic             din_valid,
  input  logic             clr_counts,
  output logic             locked,
  output logic             error_pulse,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] error_count
);

  localparam int MW = (LOCK_COUNT   < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int UW = (UNLOCK_COUNT < 2) ? 1 : $clog2(UNLOCK_COUNT + 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       expected, exp_nxt;
  logic [MW-1:0]    match_cnt, match_nxt;
  logic [UW-1:0]    miss_cnt, miss_nxt;
  logic [ERR_W-1:0] cnt_nxt;
  logic             err_hit, wrap_hit;

  // One LFSR step. 0x00 maps to itself, so it can never appear in a live
  // sequence and is treated as "bus dead" rather than a seed.
  function automatic logic [7:0] lfsr_next(input logic [7:0] d);
    return {d[6], d[5] ^ d[7], d[4] ^ d[7], d[3] ^ d[7], d[2], d[1], d[0], d[7]};
  endfunction

  always_comb begin
    state_nxt = state;
    exp_nxt   = expected;
    match_nxt = match_cnt;
    miss_nxt  = miss_cnt;
    err_hit   = 1'b0;
    wrap_hit  = 1'b0;

    if (din_valid) begin
      case (state)
        ST_UNLOCKED: begin
          if (din != 8'h00) begin
            exp_nxt   = lfsr_next(din);
            match_nxt = '0;
            state_nxt = ST_ACQUIRE;
          end
        end

        ST_ACQUIRE: begin
          if (din == expected) begin
            exp_nxt = lfsr_next(din);
            if (match_cnt == MW'(LOCK_COUNT - 1)) begin
              match_nxt = '0;
              miss_nxt  = '0;
              state_nxt = ST_LOCKED;
            end else begin
              match_nxt = match_cnt + MW'(1);
            end
          end else if (din != 8'h00) begin
            // Wrong but plausible value: treat it as a fresh seed.
            exp_nxt   = lfsr_next(din);
            match_nxt = '0;
          end else begin
            state_nxt = ST_UNLOCKED;
          end
        end

        ST_LOCKED: begin
          // Flywheel: advance our own prediction so a single corrupted
          // sample does not knock the checker out of phase.
          exp_nxt = lfsr_next(expected);
          if (din == expected) begin
            miss_nxt = '0;
            wrap_hit = (din == 8'hFF);
          end else begin
            err_hit = 1'b1;
            if (miss_cnt == UW'(UNLOCK_COUNT - 1)) begin
              miss_nxt  = '0;
              state_nxt = ST_UNLOCKED;
            end else begin
              miss_nxt = miss_cnt + UW'(1);
            end
          end
        end

        default: state_nxt = ST_UNLOCKED;
      endcase
    end

    if (clr_counts)
      cnt_nxt = '0;
    else if (err_hit && (error_count != {ERR_W{1'b1}}))
      cnt_nxt = error_count + ERR_W'(1);
    else
      cnt_nxt = error_count;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= ST_UNLOCKED;
      expected    <= 8'h00;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      locked      <= 1'b0;
      error_pulse <= 1'b0;
      wrap_pulse  <= 1'b0;
      error_count <= '0;
    end else begin
      state       <= state_nxt;
      expected    <= exp_nxt;
      match_cnt   <= match_nxt;
      miss_cnt    <= miss_nxt;
      locked      <= (state_nxt == ST_LOCKED);
      error_pulse <= err_hit;
      wrap_pulse  <= wrap_hit;
      error_count <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_lfsr8_sequence_checker.sv
// Directed-vector bench for lfsr8_sequence_checker (ERR_W=2 so saturation
// is reachable in a few samples). Each table row is one clock: inputs are
// driven, the edge is taken, and outputs are compared 1 time unit later.
// A randomized-gap run over the full sequence follows the table.

module tb_lfsr8_sequence_checker;

  logic       aclk = 1'b0;
  logic       areset;
  logic [7:0] din;
  logic       din_valid;
  logic       clr_counts;
  logic       locked, error_pulse, wrap_pulse;
  logic [1:0] error_count;

  always #5 aclk = ~aclk;

  lfsr8_sequence_checker #(
    .LOCK_COUNT  (4),
    .UNLOCK_COUNT(3),
    .ERR_W       (2)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .din        (din),
    .din_valid  (din_valid),
    .clr_counts (clr_counts),
    .locked     (locked),
    .error_pulse(error_pulse),
    .wrap_pulse (wrap_pulse),
    .error_count(error_count)
  );

  typedef struct packed {
    logic       rst, vld, clr;
    logic [7:0] din;
    logic       lk, er, wr;
    logic [1:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int   vectors = 0;
  int   errors  = 0;

  function automatic vec_t mk(input logic rst, vld, clr, input logic [7:0] d,
                              input logic lk, er, wr, input logic [1:0] cnt);
    vec_t v;
    v = '{rst: rst, vld: vld, clr: clr, din: d, lk: lk, er: er, wr: wr, cnt: cnt};
    return v;
  endfunction

  // Rotate-left then xor taps: same sequence written independently.
  function automatic logic [7:0] ref_next(input logic [7:0] d);
    logic [7:0] r;
    r = {d[6:0], d[7]};
    if (d[7]) r = r ^ 8'h70;
    return r;
  endfunction

  task automatic check(input string name, input logic lk, er, wr, input logic [1:0] cnt);
    vectors++;
    if (locked !== lk || error_pulse !== er || wrap_pulse !== wr || error_count !== cnt) begin
      errors++;
      $display("FAIL %s: got lk=%0b er=%0b wr=%0b cnt=%0d, want lk=%0b er=%0b wr=%0b cnt=%0d",
               name, locked, error_pulse, wrap_pulse, error_count, lk, er, wr, cnt);
    end
  endtask

  initial begin
    //                 rst vld clr din    lk er wr cnt
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0)); // 0 reset
    tbl.push_back(mk(0, 1, 0, 8'hFF, 0, 0, 0, 0)); // 1 seed
    tbl.push_back(mk(0, 1, 0, 8'h8F, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h6F, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'hDE, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'hCD, 1, 0, 0, 0)); // 5 4th match -> locked
    tbl.push_back(mk(0, 1, 0, 8'hEB, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 0, 1)); // 7 0x00 in place of A7
    tbl.push_back(mk(0, 1, 0, 8'h3F, 1, 0, 0, 1)); // flywheel match
    tbl.push_back(mk(0, 1, 0, 8'h7E, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 8'hFC, 1, 0, 0, 0)); // 10 clear
    tbl.push_back(mk(0, 1, 0, 8'h11, 1, 1, 0, 1)); // 3 wrong nonzero
    tbl.push_back(mk(0, 1, 0, 8'h11, 1, 1, 0, 2));
    tbl.push_back(mk(0, 1, 0, 8'h11, 0, 1, 0, 3)); // 13 unlock, still counted
    tbl.push_back(mk(0, 1, 0, 8'hFF, 0, 0, 0, 3)); // relock: seed + 4
    tbl.push_back(mk(0, 1, 0, 8'h8F, 0, 0, 0, 3));
    tbl.push_back(mk(0, 1, 0, 8'h6F, 0, 0, 0, 3));
    tbl.push_back(mk(0, 1, 0, 8'hDE, 0, 0, 0, 3));
    tbl.push_back(mk(0, 1, 0, 8'hCD, 1, 0, 0, 3));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 0, 3)); // 19 saturated
    tbl.push_back(mk(0, 1, 1, 8'h00, 1, 1, 0, 0)); // clear beats increment
    tbl.push_back(mk(0, 1, 0, 8'h3F, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 0)); // 22 invalid ignored
    tbl.push_back(mk(0, 1, 0, 8'h7E, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 0, 1)); // 24 five misses, interleaved
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 0, 2));
    tbl.push_back(mk(0, 1, 0, 8'h63, 1, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 0, 3));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 0, 3));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 0, 3)); // 29 unlock
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 3)); // 0x00 no seed
    tbl.push_back(mk(0, 0, 1, 8'h00, 0, 0, 0, 0)); // 31 clear while idle
    tbl.push_back(mk(0, 1, 0, 8'hFF, 0, 0, 0, 0)); // seed
    tbl.push_back(mk(0, 1, 0, 8'h6F, 0, 0, 0, 0)); // reseed
    tbl.push_back(mk(0, 1, 0, 8'hDE, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'hCD, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 0)); // 36 0x00 -> unlocked
    tbl.push_back(mk(0, 1, 0, 8'hEB, 0, 0, 0, 0)); // seed
    tbl.push_back(mk(0, 1, 0, 8'hA7, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h3F, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h7E, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'hFC, 1, 0, 0, 0)); // 41 locked
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 8'h63, 0, 0, 0, 0)); // 43 reset mid-LOCKED
    tbl.push_back(mk(0, 1, 0, 8'hFF, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h8F, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 8'h6F, 0, 0, 0, 0)); // 46 reset mid-ACQUIRE
    tbl.push_back(mk(0, 1, 0, 8'hDE, 0, 0, 0, 0)); // fresh seed
    tbl.push_back(mk(0, 1, 0, 8'hCD, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'hEB, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'hA7, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h3F, 1, 0, 0, 0)); // 51 locked
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0, 0)); // 52 reset
    tbl.push_back(mk(0, 1, 0, 8'h69, 0, 0, 0, 0)); // seed, leads into 0xFF
    tbl.push_back(mk(0, 1, 0, 8'hD2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'hD5, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'hDB, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'hC7, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'hFF, 1, 0, 1, 0)); // 58 wrap
    tbl.push_back(mk(0, 1, 0, 8'h8F, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'hFF, 1, 1, 0, 1)); // 60 mispredicted 0xFF: no wrap
    tbl.push_back(mk(0, 1, 0, 8'hDE, 1, 0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      areset     = tbl[i].rst;
      din_valid  = tbl[i].vld;
      clr_counts = tbl[i].clr;
      din        = tbl[i].din;
      @(posedge aclk);
      #1;
      check($sformatf("vec%0d", i), tbl[i].lk, tbl[i].er, tbl[i].wr, tbl[i].cnt);
    end

    // Full sequence from seed 0x8F with random gaps; garbage on invalid cycles.
    begin
      logic [7:0] cur;
      int n, wr_exp, wr_got;
      logic v, exp_wr;
      areset = 1'b1; din_valid = 1'b0; clr_counts = 1'b1; din = 8'h00;
      @(posedge aclk);
      #1;
      check("gap_reset", 1'b0, 1'b0, 1'b0, 2'd0);
      areset = 1'b0; clr_counts = 1'b0;
      cur = 8'h8F; n = 0; wr_exp = 0; wr_got = 0;
      for (int c = 0; c < 4000 && n < 600; c++) begin
        v         = 1'($urandom_range(0, 1));
        din_valid = v;
        din       = v ? cur : 8'($urandom);
        exp_wr    = v && (n >= 5) && (cur == 8'hFF);
        if (v) begin
          n++;
          cur = ref_next(cur);
        end
        @(posedge aclk);
        #1;
        if (exp_wr) wr_exp++;
        if (wrap_pulse) wr_got++;
        check($sformatf("gap_c%0d", c), n >= 5, 1'b0, exp_wr, 2'd0);
      end
      vectors++;
      if (wr_got != wr_exp || wr_got == 0) begin
        errors++;
        $display("FAIL gap_wrap_total: got %0d wraps, want %0d (nonzero)", wr_got, wr_exp);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
